// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: widths, arbiter
// priority state and the write-request record.
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_wb_output_stage.sv
// Registered register-file write port: drops writes to register 0 and
// holds the last address/data when nothing is written.
module wb_output_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeRegAddress,
  output logic [DATA_WIDTH-1:0] writeData
);

  logic we_q;
  logic wr;

  assign wr = valid && (addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q            <= 1'b0;
      writeRegAddress <= '0;
      writeData       <= '0;
    end else begin
      we_q <= wr;
      if (wr) begin
        writeRegAddress <= addr;
        writeData       <= data;
      end
    end
  end

  // A write already registered when reset arrives must not reach the regfile.
  assign writeEnable = we_q && !reset;

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester writeback arbiter for the register file: memory priority
// with a bounded-wait override that forces an ALU grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aluValid,
  input  logic [ADDR_WIDTH-1:0] aluAddr,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  aluReady,
  input  logic                  memValid,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  memReady,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeRegAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [3:0]            aluWaitCount
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  arb_state_e state, state_nxt;
  logic       alu_win, mem_win;
  logic       sel_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_ff @(posedge clk) begin
    if (reset) state <= PRI_MEM;
    else       state <= state_nxt;
  end

  // Leave PRI_MEM on the loss that would make the wait reach MAX_WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      PRI_MEM: if (aluValid && mem_win && (aluWaitCount + 4'd1 == MAX_W)) state_nxt = PRI_ALU;
      PRI_ALU: if (alu_win) state_nxt = PRI_MEM;
      default: state_nxt = PRI_MEM;
    endcase
  end

  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (!reset) begin
      case (state)
        PRI_MEM: begin
          if (memValid)      mem_win = 1'b1;
          else if (aluValid) alu_win = 1'b1;
        end
        PRI_ALU: begin
          if (aluValid)      alu_win = 1'b1;
          else if (memValid) mem_win = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    aluWaitCount <= 4'd0;
    else if (!aluValid || alu_win) aluWaitCount <= 4'd0;
    else if (mem_win && aluWaitCount < MAX_W) aluWaitCount <= aluWaitCount + 4'd1;
  end

  assign aluReady  = alu_win;
  assign memReady  = mem_win;
  assign sel_valid = alu_win || mem_win;
  assign sel_addr  = alu_win ? aluAddr : memAddr;
  assign sel_data  = alu_win ? aluData : memData;

  wb_output_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_out (
    .clk            (clk),
    .reset          (reset),
    .valid          (sel_valid),
    .addr           (sel_addr),
    .data           (sel_data),
    .writeEnable    (writeEnable),
    .writeRegAddress(writeRegAddress),
    .writeData      (writeData)
  );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed test-plan sequences plus a random
// phase, with a scoreboard of expected writes and a reference arbiter model.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid, memValid;
  logic [4:0]  aluAddr, memAddr;
  logic [31:0] aluData, memData;
  logic        aluReady, memReady;
  logic        writeEnable;
  logic [4:0]  writeRegAddress;
  logic [31:0] writeData;
  logic [3:0]  aluWaitCount;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [32] = '{default: 32'h0};
  wr_req_t     sb [$];
  arb_state_e  m_state = PRI_MEM;
  int          m_cnt = 0;
  logic        alu_took = 1'b0, mem_took = 1'b0;

  reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(MAXW)) dut (
    .clk            (clk),
    .reset          (reset),
    .aluValid       (aluValid),
    .aluAddr        (aluAddr),
    .aluData        (aluData),
    .aluReady       (aluReady),
    .memValid       (memValid),
    .memAddr        (memAddr),
    .memData        (memData),
    .memReady       (memReady),
    .writeEnable    (writeEnable),
    .writeRegAddress(writeRegAddress),
    .writeData      (writeData),
    .aluWaitCount   (aluWaitCount)
  );

  always #5 clk = ~clk;

  // Register file fed by the arbiter; register 0 is never written.
  always @(posedge clk)
    if (writeEnable && writeRegAddress != 5'd0) rf[writeRegAddress] <= writeData;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic    ma, mm;
    wr_req_t e;
    ma = 1'b0;
    mm = 1'b0;
    if (!reset) begin
      if (m_state == PRI_MEM) begin
        if (memValid) mm = 1'b1; else if (aluValid) ma = 1'b1;
      end else begin
        if (aluValid) ma = 1'b1; else if (memValid) mm = 1'b1;
      end
    end
    chk("alu_ready", {31'd0, aluReady}, {31'd0, ma});
    chk("mem_ready", {31'd0, memReady}, {31'd0, mm});
    chk("wait_cnt", {28'd0, aluWaitCount}, 32'(m_cnt));
    if (reset) begin
      chk("we_in_reset", {31'd0, writeEnable}, 32'd0);
      sb.delete();
    end else begin
      chk("we", {31'd0, writeEnable}, {31'd0, sb.size() != 0});
      if (writeEnable && sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", {27'd0, writeRegAddress}, {27'd0, e.addr});
        chk("wr_data", writeData, e.data);
      end
    end
    e.valid = 1'b1;
    if (ma && aluAddr != 5'd0) begin e.addr = aluAddr; e.data = aluData; sb.push_back(e); end
    if (mm && memAddr != 5'd0) begin e.addr = memAddr; e.data = memData; sb.push_back(e); end
    alu_took = aluValid && aluReady;
    mem_took = memValid && memReady;
    if (reset) begin
      m_state = PRI_MEM;
      m_cnt   = 0;
    end else begin
      if (m_state == PRI_MEM && mm && aluValid && m_cnt + 1 == MAXW) m_state = PRI_ALU;
      else if (m_state == PRI_ALU && ma) m_state = PRI_MEM;
      if (!aluValid || ma) m_cnt = 0;
      else if (mm && m_cnt < MAXW) m_cnt++;
    end
  end

  initial begin
    int exp_cnt [5] = '{0, 1, 2, 3, 0};
    int exp_alu [5] = '{0, 0, 0, 1, 0};

    // Reset hold with both requesters asserting.
    reset = 1'b1;
    aluValid = 1'b1; aluAddr = 5'd3; aluData = 32'h33;
    memValid = 1'b1; memAddr = 5'd5; memData = 32'h50;
    repeat (3) begin
      @(negedge clk);
      chk("rst_alu_rdy", {31'd0, aluReady}, 32'd0);
      chk("rst_mem_rdy", {31'd0, memReady}, 32'd0);
      chk("rst_we", {31'd0, writeEnable}, 32'd0);
      cyc();
    end
    reset = 1'b0;

    // Continuous memory traffic: ALU forced in on the fourth cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stv_cnt", {28'd0, aluWaitCount}, 32'(exp_cnt[k]));
      chk("stv_alu", {31'd0, aluReady}, 32'(exp_alu[k]));
      chk("stv_mem", {31'd0, memReady}, 32'(1 - exp_alu[k]));
      if (k == 0) begin
        chk("rst_waddr", {27'd0, writeRegAddress}, 32'd0);
        chk("rst_wdata", writeData, 32'd0);
      end
      cyc();
      memData = memData + 32'd1;
      if (k == 3) aluValid = 1'b0;
    end
    memValid = 1'b0;
    cyc();
    chk("stv_rf3", rf[3], 32'h33);
    chk("stv_rf5", rf[5], 32'h54);

    // Single ALU write.
    aluValid = 1'b1; aluAddr = 5'd7; aluData = 32'hAA;
    @(negedge clk);
    chk("alu1_rdy", {31'd0, aluReady}, 32'd1);
    cyc();
    aluValid = 1'b0;
    @(negedge clk);
    chk("alu1_we", {31'd0, writeEnable}, 32'd1);
    chk("alu1_addr", {27'd0, writeRegAddress}, 32'd7);
    chk("alu1_data", writeData, 32'hAA);
    cyc();
    chk("alu1_rf7", rf[7], 32'hAA);

    // Write to register 0 handshakes but is dropped.
    memValid = 1'b1; memAddr = 5'd0; memData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("r0_rdy", {31'd0, memReady}, 32'd1);
    cyc();
    memValid = 1'b0;
    @(negedge clk);
    chk("r0_we", {31'd0, writeEnable}, 32'd0);
    chk("r0_hold_addr", {27'd0, writeRegAddress}, 32'd7);
    chk("r0_hold_data", writeData, 32'hAA);
    cyc();

    // Same destination: memory first, ALU value is final.
    aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'd1;
    memValid = 1'b1; memAddr = 5'd4; memData = 32'd2;
    @(negedge clk);
    chk("same_mem_rdy", {31'd0, memReady}, 32'd1);
    cyc();
    memValid = 1'b0;
    @(negedge clk);
    chk("same_alu_rdy", {31'd0, aluReady}, 32'd1);
    chk("same_w1", writeData, 32'd2);
    cyc();
    aluValid = 1'b0;
    @(negedge clk);
    chk("same_w2", writeData, 32'd1);
    cyc();
    chk("same_rf4", rf[4], 32'd1);

    // Mid-stream reset after the wait counter has built up.
    aluValid = 1'b1; aluAddr = 5'd9; aluData = 32'h99;
    memValid = 1'b1; memAddr = 5'd10; memData = 32'hA0;
    @(negedge clk);
    cyc();
    memAddr = 5'd11; memData = 32'hB0;
    @(negedge clk);
    chk("mid_cnt1", {28'd0, aluWaitCount}, 32'd1);
    cyc();
    memAddr = 5'd12; memData = 32'hC0;
    @(negedge clk);
    chk("mid_mem_rdy", {31'd0, memReady}, 32'd1);
    chk("mid_cnt2", {28'd0, aluWaitCount}, 32'd2);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_we", {31'd0, writeEnable}, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rf12", rf[12], 32'd0);
    chk("mid_cnt0", {28'd0, aluWaitCount}, 32'd0);
    chk("mid_state_mem", {31'd0, memReady}, 32'd1);
    cyc();
    memValid = 1'b0;
    @(negedge clk);
    chk("mid_alu_rdy", {31'd0, aluReady}, 32'd1);
    cyc();
    aluValid = 1'b0;
    cyc();

    // Random traffic honouring the hold-until-accepted rule.
    for (int i = 0; i < 400; i++) begin
      if (!aluValid || alu_took) begin
        aluValid = $urandom_range(0, 2) != 0;
        aluAddr  = 5'($urandom);
        aluData  = $urandom;
      end
      if (!memValid || mem_took) begin
        memValid = $urandom_range(0, 2) != 0;
        memAddr  = 5'($urandom);
        memData  = $urandom;
      end
      reset = ($urandom_range(0, 60) == 0);
      cyc();
    end
    reset = 1'b0; aluValid = 1'b0; memValid = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
